// File: rtl/halt_if.sv
// halt_if: groups the ID-stage, forwarding-network and halt-status signals
// shared between a pipelined core and its halt controller.
//   master : core side; drives ID/forwarding inputs, observes halt status
//   slave  : halt controller side
// Signals:
//   is_ecall, id_valid, stall, flush, id_pc  - instruction currently in ID
//   rf_sys_data                               - register-file read of the syscall register
//   ex_/mem_/wb_ wr_en, rd, data               - writeback info of the later stages
//   ex_data_ok                                 - EX result is available (low for a load)
//   halt_request, need_stall, is_halted, halt_pc, unknown_ecall, drain_count - status
interface halt_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic            is_ecall;
    logic            id_valid;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] rf_sys_data;

    logic            ex_wr_en;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            ex_data_ok;
    logic            mem_wr_en;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_wr_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic             halt_request;
    logic             need_stall;
    logic             is_halted;
    logic [XLEN-1:0]  halt_pc;
    logic             unknown_ecall;
    logic [CNT_W-1:0] drain_count;

    modport master (
        output is_ecall, id_valid, stall, flush, id_pc, rf_sys_data,
               ex_wr_en, ex_rd, ex_data, ex_data_ok,
               mem_wr_en, mem_rd, mem_data,
               wb_wr_en, wb_rd, wb_data,
        input  halt_request, need_stall, is_halted, halt_pc, unknown_ecall, drain_count
    );

    modport slave (
        input  is_ecall, id_valid, stall, flush, id_pc, rf_sys_data,
               ex_wr_en, ex_rd, ex_data, ex_data_ok,
               mem_wr_en, mem_rd, mem_data,
               wb_wr_en, wb_rd, wb_data,
        output halt_request, need_stall, is_halted, halt_pc, unknown_ecall, drain_count
    );
endinterface

// File: rtl/halt_controller.sv
// halt_controller: sits beside the ID stage of a pipelined core. Resolves the
// syscall-number register through the EX/MEM/WB forwarding network, detects
// the halt ecall, requests a fetch stop, waits a programmable drain window so
// older instructions retire, then raises a sticky halted flag with the PC of
// the halting ecall.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   hif   - halt_if.slave (ID inputs, forwarding inputs, halt status outputs)
module halt_controller #(
    parameter int XLEN         = 32,
    parameter int HALT_CODE    = 10,
    parameter int SYSCALL_REG  = 17,
    parameter int DRAIN_CYCLES = 4,   // 0..255
    parameter int CNT_W        = 8    // 2**CNT_W > DRAIN_CYCLES
) (
    input  logic   clk,
    input  logic   reset,
    halt_if.slave  hif
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0]       SYS_IDX  = 5'(SYSCALL_REG);
    localparam logic [XLEN-1:0]  HALT_VAL = XLEN'(HALT_CODE);
    // The accept edge itself counts as the first drain edge, so load one less.
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
    logic             unknown_q, unknown_d;

    logic             ex_hit, mem_hit, wb_hit;
    logic [XLEN-1:0]  sys_value;
    logic             need_stall;
    logic             accept;
    logic             is_halt_code;

    // x0 is hard-wired to zero, so writes targeting it are never forwarded.
    assign ex_hit  = (SYSCALL_REG != 0) && hif.ex_wr_en  && (hif.ex_rd  == SYS_IDX);
    assign mem_hit = (SYSCALL_REG != 0) && hif.mem_wr_en && (hif.mem_rd == SYS_IDX);
    assign wb_hit  = (SYSCALL_REG != 0) && hif.wb_wr_en  && (hif.wb_rd  == SYS_IDX);

    // Youngest producer wins: EX, then MEM, then WB, then the register file.
    always_comb begin
        sys_value = hif.rf_sys_data;
        if (SYSCALL_REG == 0)
            sys_value = '0;
        else if (ex_hit)
            sys_value = hif.ex_data;
        else if (mem_hit)
            sys_value = hif.mem_data;
        else if (wb_hit)
            sys_value = hif.wb_data;
    end

    // A load still in EX has no data yet; the ecall must wait in ID.
    assign need_stall   = hif.is_ecall && hif.id_valid && ex_hit && !hif.ex_data_ok;
    assign accept       = (state_q == RUN) && hif.id_valid && hif.is_ecall &&
                          !hif.stall && !hif.flush && !need_stall;
    // Full-width compare: any set upper bit means a different syscall.
    assign is_halt_code = (sys_value == HALT_VAL);

    // NOTE: every next-state signal gets its default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        halt_pc_d = halt_pc_q;
        unknown_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (is_halt_code) begin
                        halt_pc_d = hif.id_pc;
                        if (DRAIN_CYCLES == 0) begin
                            state_d = HALTED;
                        end else begin
                            state_d = DRAIN;
                            count_d = DRAIN_LOAD;
                        end
                    end else begin
                        unknown_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Drain cannot be cancelled; only reset leaves this state early.
                if (count_q == '0)
                    state_d = HALTED;
                else
                    count_d = count_q - CNT_W'(1);
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            count_q   <= '0;
            halt_pc_q <= '0;
            unknown_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            halt_pc_q <= halt_pc_d;
            unknown_q <= unknown_d;
        end
    end

    // Combinational in the accept cycle so fetch stops without a bubble.
    assign hif.halt_request  = (accept && is_halt_code) || (state_q != RUN);
    assign hif.need_stall    = need_stall;
    assign hif.is_halted     = (state_q == HALTED);
    assign hif.halt_pc       = halt_pc_q;
    assign hif.unknown_ecall = unknown_q;
    assign hif.drain_count   = (state_q == DRAIN) ? count_q : '0;
endmodule

// File: tb/tb_halt_controller.sv
// tb_halt_controller: drives two halt_controller builds side by side
// (XLEN=32/DRAIN_CYCLES=4 and XLEN=64/DRAIN_CYCLES=0) with directed scenarios
// followed by random traffic. A reference model, expressed in terms of the
// cycle at which the core becomes halted, pushes the expected outputs of every
// cycle into a per-DUT queue; a monitor pops and compares on the falling edge.
module tb_halt_controller;
    localparam int D0 = 4;
    localparam int D1 = 0;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    halt_if #(.XLEN(32), .CNT_W(8)) if0 ();
    halt_if #(.XLEN(64), .CNT_W(8)) if1 ();

    halt_controller #(.XLEN(32), .HALT_CODE(10), .SYSCALL_REG(17),
                      .DRAIN_CYCLES(D0), .CNT_W(8))
        dut0 (.clk(clk), .reset(rst0), .hif(if0));
    halt_controller #(.XLEN(64), .HALT_CODE(10), .SYSCALL_REG(17),
                      .DRAIN_CYCLES(D1), .CNT_W(8))
        dut1 (.clk(clk), .reset(rst1), .hif(if1));

    typedef struct {
        logic        is_ecall, id_valid, stall, flush;
        logic [63:0] id_pc, rf, ex_data, mem_data, wb_data;
        logic        ex_wr_en, ex_data_ok, mem_wr_en, wb_wr_en;
        logic [4:0]  ex_rd, mem_rd, wb_rd;
    } stim_t;

    typedef struct {
        logic        halt_request, need_stall, is_halted, unknown_ecall;
        logic [63:0] halt_pc;
        int          drain_count;
        longint      cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: halt_at < 0 means running, otherwise the cycle from which
    // is_halted is visible; cycles before it are the drain window.
    longint      cyc = 0;
    longint      halt_at[2]     = '{-1, -1};
    logic [63:0] m_pc[2]        = '{64'd0, 64'd0};
    bit          m_unk[2]       = '{1'b0, 1'b0};
    longint      nxt_halt_at[2] = '{-1, -1};
    logic [63:0] nxt_pc[2]      = '{64'd0, 64'd0};
    bit          nxt_unk[2]     = '{1'b0, 1'b0};
    int          drain_of[2]    = '{D0, D1};
    logic [63:0] mask_of[2]     = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    task automatic model_cycle(input int k, input stim_t s, input bit r, output exp_t e);
        logic [63:0] v;
        bit hit_ex, hit_mem, hit_wb, ns, running, acc, is_halt;
        if (r) begin
            halt_at[k] = -1;
            m_pc[k]    = 64'd0;
            m_unk[k]   = 1'b0;
        end
        hit_ex  = s.ex_wr_en  && s.ex_rd  == 5'd17;
        hit_mem = s.mem_wr_en && s.mem_rd == 5'd17;
        hit_wb  = s.wb_wr_en  && s.wb_rd  == 5'd17;
        if (hit_ex)       v = s.ex_data;
        else if (hit_mem) v = s.mem_data;
        else if (hit_wb)  v = s.wb_data;
        else              v = s.rf;
        v       = v & mask_of[k];
        ns      = s.is_ecall && s.id_valid && hit_ex && !s.ex_data_ok;
        running = halt_at[k] < 0;
        acc     = running && s.id_valid && s.is_ecall && !s.stall && !s.flush && !ns;
        is_halt = (v == 64'd10);

        e.halt_request  = (acc && is_halt) || !running;
        e.need_stall    = ns;
        e.is_halted     = !running && cyc >= halt_at[k];
        e.drain_count   = (!running && cyc < halt_at[k]) ? int'(halt_at[k] - cyc - 1) : 0;
        e.halt_pc       = m_pc[k];
        e.unknown_ecall = m_unk[k];
        e.cyc           = cyc;

        nxt_halt_at[k] = halt_at[k];
        nxt_pc[k]      = m_pc[k];
        nxt_unk[k]     = 1'b0;
        if (acc && is_halt) begin
            nxt_halt_at[k] = cyc + drain_of[k] + 1;
            nxt_pc[k]      = s.id_pc & mask_of[k];
        end else if (acc) begin
            nxt_unk[k] = 1'b1;
        end
    endtask

    task automatic apply(input stim_t s0, input stim_t s1);
        if0.is_ecall = s0.is_ecall;     if1.is_ecall = s1.is_ecall;
        if0.id_valid = s0.id_valid;     if1.id_valid = s1.id_valid;
        if0.stall    = s0.stall;        if1.stall    = s1.stall;
        if0.flush    = s0.flush;        if1.flush    = s1.flush;
        if0.id_pc       = s0.id_pc[31:0];    if1.id_pc       = s1.id_pc;
        if0.rf_sys_data = s0.rf[31:0];       if1.rf_sys_data = s1.rf;
        if0.ex_wr_en   = s0.ex_wr_en;        if1.ex_wr_en   = s1.ex_wr_en;
        if0.ex_rd      = s0.ex_rd;           if1.ex_rd      = s1.ex_rd;
        if0.ex_data    = s0.ex_data[31:0];   if1.ex_data    = s1.ex_data;
        if0.ex_data_ok = s0.ex_data_ok;      if1.ex_data_ok = s1.ex_data_ok;
        if0.mem_wr_en  = s0.mem_wr_en;       if1.mem_wr_en  = s1.mem_wr_en;
        if0.mem_rd     = s0.mem_rd;          if1.mem_rd     = s1.mem_rd;
        if0.mem_data   = s0.mem_data[31:0];  if1.mem_data   = s1.mem_data;
        if0.wb_wr_en   = s0.wb_wr_en;        if1.wb_wr_en   = s1.wb_wr_en;
        if0.wb_rd      = s0.wb_rd;           if1.wb_rd      = s1.wb_rd;
        if0.wb_data    = s0.wb_data[31:0];   if1.wb_data    = s1.wb_data;
    endtask

    // One clock cycle: commit the model at the edge, then drive and predict.
    task automatic drive_cycle(input stim_t s0_in, input stim_t s1_in,
                               input bit r0, input bit r1);
        stim_t s0, s1;
        exp_t  e;
        s0 = s0_in;
        s1 = s1_in;
        if (r0) s0.is_ecall = 1'b0;
        if (r1) s1.is_ecall = 1'b0;
        @(posedge clk);
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            halt_at[k] = nxt_halt_at[k];
            m_pc[k]    = nxt_pc[k];
            m_unk[k]   = nxt_unk[k];
        end
        #1;
        rst0 = r0;
        rst1 = r1;
        apply(s0, s1);
        model_cycle(0, s0, r0, e);
        q0.push_back(e);
        model_cycle(1, s1, r1, e);
        q1.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t ecall_rf(input logic [63:0] pc, input logic [63:0] val);
        stim_t s;
        s          = idle();
        s.is_ecall = 1'b1;
        s.id_valid = 1'b1;
        s.id_pc    = pc;
        s.rf       = val;
        return s;
    endfunction

    function automatic logic [63:0] pick_data();
        case ($urandom_range(0, 4))
            0, 1:    return 64'd10;
            2:       return 64'd93;
            3:       return 64'h1_0000_000A;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [4:0] pick_rd();
        if ($urandom_range(0, 1) == 0) return 5'd17;
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.is_ecall   = ($urandom_range(0, 2) == 0);
        s.id_valid   = ($urandom_range(0, 3) != 0);
        s.stall      = ($urandom_range(0, 5) == 0);
        s.flush      = ($urandom_range(0, 5) == 0);
        s.id_pc      = {$urandom, $urandom};
        s.rf         = pick_data();
        s.ex_data    = pick_data();
        s.mem_data   = pick_data();
        s.wb_data    = pick_data();
        s.ex_wr_en   = 1'($urandom_range(0, 1));
        s.mem_wr_en  = 1'($urandom_range(0, 1));
        s.wb_wr_en   = 1'($urandom_range(0, 1));
        s.ex_data_ok = ($urandom_range(0, 3) != 0);
        s.ex_rd      = pick_rd();
        s.mem_rd     = pick_rd();
        s.wb_rd      = pick_rd();
        return s;
    endfunction

    task automatic check(input string name, input longint c,
                         input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, c, act, exp_v);
        end
    endtask

    task automatic compare(input string tag, input exp_t a, input exp_t e);
        check({tag, ".halt_request"},  e.cyc, 64'(a.halt_request),  64'(e.halt_request));
        check({tag, ".need_stall"},    e.cyc, 64'(a.need_stall),    64'(e.need_stall));
        check({tag, ".is_halted"},     e.cyc, 64'(a.is_halted),     64'(e.is_halted));
        check({tag, ".unknown_ecall"}, e.cyc, 64'(a.unknown_ecall), 64'(e.unknown_ecall));
        check({tag, ".halt_pc"},       e.cyc, a.halt_pc,            e.halt_pc);
        check({tag, ".drain_count"},   e.cyc, 64'(a.drain_count),   64'(e.drain_count));
    endtask

    // Monitor: independent of the stimulus; compares whatever is queued.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a.halt_request  = if0.halt_request;
                a.need_stall    = if0.need_stall;
                a.is_halted     = if0.is_halted;
                a.unknown_ecall = if0.unknown_ecall;
                a.halt_pc       = 64'(if0.halt_pc);
                a.drain_count   = int'(if0.drain_count);
                a.cyc           = e.cyc;
                compare("dut0", a, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a.halt_request  = if1.halt_request;
                a.need_stall    = if1.need_stall;
                a.is_halted     = if1.is_halted;
                a.unknown_ecall = if1.unknown_ecall;
                a.halt_pc       = if1.halt_pc;
                a.drain_count   = int'(if1.drain_count);
                a.cyc           = e.cyc;
                compare("dut1", a, e);
            end
        end
    end

    initial begin
        stim_t s;
        rst0 = 1'b1;
        rst1 = 1'b1;
        apply(idle(), idle());

        // Reset state.
        repeat (2) drive_cycle(idle(), idle(), 1'b1, 1'b1);
        drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Halt from the register file, then watch the drain window.
        s = ecall_rf(64'h40, 64'd10);
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (7) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Forwarding priority: MEM 93 over WB 10 -> unknown; then EX 10 wins.
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        s = ecall_rf(64'h80, 64'd0);
        s.wb_wr_en  = 1'b1; s.wb_rd  = 5'd17; s.wb_data  = 64'd10;
        s.mem_wr_en = 1'b1; s.mem_rd = 5'd17; s.mem_data = 64'd93;
        drive_cycle(s, s, 1'b0, 1'b0);
        drive_cycle(idle(), idle(), 1'b0, 1'b0);
        s.ex_wr_en = 1'b1; s.ex_rd = 5'd17; s.ex_data = 64'd10; s.ex_data_ok = 1'b1;
        s.id_pc    = 64'h84;
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (6) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Load-use: stall while the load is in EX, accept from MEM next cycle.
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        s = ecall_rf(64'hC0, 64'd0);
        s.ex_wr_en = 1'b1; s.ex_rd = 5'd17; s.ex_data = 64'd10; s.ex_data_ok = 1'b0;
        drive_cycle(s, s, 1'b0, 1'b0);
        s = ecall_rf(64'hC0, 64'd0);
        s.mem_wr_en = 1'b1; s.mem_rd = 5'd17; s.mem_data = 64'd10;
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (6) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Squash and stall block the ecall; both low lets it through.
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        s = ecall_rf(64'h100, 64'd10);
        s.flush = 1'b1;
        drive_cycle(s, s, 1'b0, 1'b0);
        s.flush = 1'b0; s.stall = 1'b1;
        drive_cycle(s, s, 1'b0, 1'b0);
        s.stall = 1'b0;
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (6) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Reset mid-drain, then a fresh halt.
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        s = ecall_rf(64'h140, 64'd10);
        drive_cycle(s, s, 1'b0, 1'b0);
        drive_cycle(idle(), idle(), 1'b0, 1'b0);
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        drive_cycle(idle(), idle(), 1'b0, 1'b0);
        s = ecall_rf(64'h40, 64'd10);
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (7) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Upper bits set: no halt at 64 bits (truncates to 10 at 32 bits).
        drive_cycle(idle(), idle(), 1'b1, 1'b1);
        s = ecall_rf(64'h1_0000_0200, 64'h1_0000_000A);
        drive_cycle(s, s, 1'b0, 1'b0);
        drive_cycle(idle(), idle(), 1'b0, 1'b0);
        s = ecall_rf(64'hFFFF_0000_0000_0204, 64'd10);
        drive_cycle(s, s, 1'b0, 1'b0);
        repeat (3) drive_cycle(idle(), idle(), 1'b0, 1'b0);

        // Random traffic with occasional resets to leave the halted state.
        for (int i = 0; i < 600; i++) begin
            drive_cycle(rnd(), rnd(),
                        ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0));
        end

        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: got %0d/%0d entries left, want 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
